cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) among NUM_REQ functional units (ALU, MUL, DIV, LSU).
- Each unit presents a completed result (tag + value) through a valid/ready handshake.
- The arbiter buffers one result per unit, picks one buffered result per cycle with round-robin priority, and broadcasts it to the reservation stations, ROB and register file.
- Flush drops all buffered, not-yet-broadcast results on a mispredict.

---
 rtl/cdb_arbiter.sv | 100 ++++++++++
 tb/tb_cdb_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with one result slot per functional unit
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_value,
  output logic [NUM_REQ-1:0]        grant
);

  localparam int             PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] slot_valid;
  logic [TAG_W-1:0]   slot_tag   [NUM_REQ];
  logic [DATA_W-1:0]  slot_value [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   rr_next;
  logic [PTR_W:0]     scan_sum;
  logic [PTR_W-1:0]   scan_idx;

  // Scan from rr_ptr with wraparound; one extra bit keeps the modulo exact for any NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_sum >= NUM_REQ_W) begin
        scan_sum = scan_sum - NUM_REQ_W;
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!win_found && slot_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    grant     = '0;
    cdb_valid = 1'b0;
    cdb_tag   = '0;
    cdb_value = '0;
    if (win_found) begin
      cdb_tag   = slot_tag[win_idx];
      cdb_value = slot_value[win_idx];
      if (!flush) begin
        cdb_valid      = 1'b1;
        grant[win_idx] = 1'b1;
      end
    end
  end

  assign rr_next   = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
  // A granted slot drains this cycle, so it can accept a replacement in the same edge.
  assign req_ready = flush ? '0 : (~slot_valid | grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_tag[i]   <= '0;
        slot_value[i] <= '0;
      end
    end else if (flush) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          slot_valid[i] <= 1'b1;
          slot_tag[i]   <= req_tag[i*TAG_W +: TAG_W];
          slot_value[i] <= req_value[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      if (win_found) begin
        rr_ptr <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [15:0]  req_tag = '0;
  logic [127:0] req_value = '0;
  logic [3:0]   req_ready;
  logic         cdb_valid;
  logic [3:0]   cdb_tag;
  logic [31:0]  cdb_value;
  logic [3:0]   grant;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] value;
    logic [3:0]  grant;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  cdb_arbiter #(.NUM_REQ(4), .TAG_W(4), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_value (req_value),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  // Every broadcast must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && cdb_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_broadcast tag=%h value=%h grant=%b required no broadcast",
                 cdb_tag, cdb_value, grant);
      end else begin
        mon_e = exp_q.pop_front();
        if ({cdb_tag, cdb_value, grant} !== mon_e) begin
          errors++;
          $display("FAIL broadcast got tag=%h value=%h grant=%b required tag=%h value=%h grant=%b",
                   cdb_tag, cdb_value, grant, mon_e.tag, mon_e.value, mon_e.grant);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input logic [3:0] t, input logic [31:0] v);
    req_valid[u]         = 1'b1;
    req_tag[u*4 +: 4]    = t;
    req_value[u*32 +: 32] = v;
  endtask

  task automatic push(input logic [3:0] t, input logic [31:0] v, input logic [3:0] g);
    exp_t e;
    e.tag   = t;
    e.value = v;
    e.grant = g;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int n);
    for (int c = 0; c < n && exp_q.size() != 0; c++) tick();
    tick();
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({cdb_valid, grant, cdb_tag, cdb_value} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b grant=%b tag=%h value=%h required all zero",
               cdb_valid, grant, cdb_tag, cdb_value);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({cdb_valid, grant, req_ready} !== {1'b0, 4'b0000, 4'b1111}) begin
        errors++;
        $display("FAIL idle cycle %0d got valid=%b grant=%b ready=%b required 0 0000 1111",
                 c, cdb_valid, grant, req_ready);
      end
      tick();
    end
  endtask

  task automatic test_single();
    drive(0, 4'h3, 32'h0000_00AA);
    push(4'h3, 32'h0000_00AA, 4'b0001);
    @(negedge clk);
    checks++;
    if ({req_ready[0], cdb_valid} !== 2'b10) begin
      errors++;
      $display("FAIL single_accept got ready0=%b valid=%b required 1 0", req_ready[0], cdb_valid);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if ({cdb_valid, grant} !== {1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL single_latency got valid=%b grant=%b required 1 0001", cdb_valid, grant);
    end
    tick();
    @(negedge clk);
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got valid=%b required 0", cdb_valid);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin
        drive(0, 4'(c + 1), 32'h0000_0100 + 32'(c));
        push(4'(c + 1), 32'h0000_0100 + 32'(c), 4'b0001);
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      checks++;
      if (c < 3 && req_ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready cycle %0d got %b required 1", c, req_ready[0]);
      end else if (c > 0 && cdb_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_valid cycle %0d got %b required 1", c, cdb_valid);
      end
      tick();
    end
    wait_idle(10);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_pending got %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_contention();
    flush_pulse();
    for (int u = 0; u < 4; u++) begin
      drive(u, 4'(8 + u), 32'h1000_0000 + 32'(u));
      push(4'(8 + u), 32'h1000_0000 + 32'(u), 4'(1 << u));
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1111) begin
      errors++;
      $display("FAIL contention_accept got %b required 1111", req_ready);
    end
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({grant, req_ready[3]} !== {4'(1 << k), (k == 3)}) begin
        errors++;
        $display("FAIL contention cycle %0d got grant=%b ready3=%b required %b %b",
                 k, grant, req_ready[3], 4'(1 << k), (k == 3));
      end
      tick();
    end
    // Pointer wrapped to 0: unit 0 must beat unit 1.
    drive(0, 4'hC, 32'h0000_0C0C);
    drive(1, 4'hD, 32'h0000_0D0D);
    push(4'hC, 32'h0000_0C0C, 4'b0001);
    push(4'hD, 32'h0000_0D0D, 4'b0010);
    tick();
    req_valid = '0;
    wait_idle(10);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL contention_pending got %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_fairness();
    logic [3:0] f_tags [4];
    int         idx;
    f_tags[0] = 4'h1;
    f_tags[1] = 4'h2;
    f_tags[2] = 4'h3;
    f_tags[3] = 4'h4;
    idx = 0;
    flush_pulse();
    push(4'h1, 32'hF000_0001, 4'b0001);
    push(4'hE, 32'h0000_E00E, 4'b0100);
    push(4'h2, 32'hF000_0002, 4'b0001);
    push(4'h3, 32'hF000_0003, 4'b0001);
    push(4'h4, 32'hF000_0004, 4'b0001);
    for (int c = 0; c < 20; c++) begin
      if (idx < 4) drive(0, f_tags[idx], 32'hF000_0000 | {28'h0, f_tags[idx]});
      else req_valid[0] = 1'b0;
      if (c == 0) drive(2, 4'hE, 32'h0000_E00E);
      else req_valid[2] = 1'b0;
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if ({grant, req_ready[0]} !== {4'b0100, 1'b0}) begin
          errors++;
          $display("FAIL fairness_turn got grant=%b ready0=%b required 0100 0", grant, req_ready[0]);
        end
      end
      if (req_valid[0] && req_ready[0]) idx++;
      tick();
      if (idx == 4 && exp_q.size() == 0) break;
    end
    req_valid = '0;
    wait_idle(10);
    checks++;
    if (exp_q.size() != 0 || idx != 4) begin
      errors++;
      $display("FAIL fairness_pending got %0d accepted %0d required 0 4", exp_q.size(), idx);
    end
  endtask

  task automatic test_backpressure();
    flush_pulse();
    drive(0, 4'h6, 32'h0000_0600);
    drive(1, 4'h7, 32'h0000_0700);
    push(4'h6, 32'h0000_0600, 4'b0001);
    push(4'h7, 32'h0000_0700, 4'b0010);
    push(4'h5, 32'hDEAD_BEEF, 4'b0010);
    tick();
    req_valid[0] = 1'b0;
    drive(1, 4'h5, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if ({grant, req_ready[1]} !== {4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL bp_blocked got grant=%b ready1=%b required 0001 0", grant, req_ready[1]);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({grant, req_ready[1]} !== {4'b0010, 1'b1}) begin
      errors++;
      $display("FAIL bp_release got grant=%b ready1=%b required 0010 1", grant, req_ready[1]);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if ({grant, cdb_value} !== {4'b0010, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL bp_value got grant=%b value=%h required 0010 deadbeef", grant, cdb_value);
    end
    tick();
    @(negedge clk);
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_duplicate got valid=%b required 0", cdb_valid);
    end
    tick();
  endtask

  task automatic test_flush();
    drive(1, 4'h1, 32'h0000_0011);
    drive(3, 4'h3, 32'h0000_0033);
    tick();
    req_valid = '0;
    flush = 1'b1;
    drive(0, 4'h9, 32'h0000_0099);
    @(negedge clk);
    checks++;
    if ({cdb_valid, grant, req_ready} !== 9'd0) begin
      errors++;
      $display("FAIL flush_cycle got valid=%b grant=%b ready=%b required 0 0000 0000",
               cdb_valid, grant, req_ready);
    end
    tick();
    flush = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_lost cycle %0d got valid=%b required 0", c, cdb_valid);
      end
      tick();
    end
    // Pointer must be back at 0: unit 0 first, then unit 3.
    drive(3, 4'hA, 32'h0000_00A3);
    drive(0, 4'hB, 32'h0000_00B0);
    push(4'hB, 32'h0000_00B0, 4'b0001);
    push(4'hA, 32'h0000_00A3, 4'b1000);
    tick();
    req_valid = '0;
    wait_idle(10);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL flush_pending got %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    drive(0, 4'h1, 32'h0000_0001);
    drive(1, 4'h2, 32'h0000_0002);
    drive(2, 4'h3, 32'h0000_0003);
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (cdb_valid !== 1'b1) begin
      errors++;
      $display("FAIL prereset_valid got %b required 1", cdb_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({cdb_valid, grant} !== 5'd0) begin
      errors++;
      $display("FAIL async_reset got valid=%b grant=%b required 0 0000", cdb_valid, grant);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({cdb_valid, req_ready} !== {1'b0, 4'b1111}) begin
        errors++;
        $display("FAIL post_reset cycle %0d got valid=%b ready=%b required 0 1111",
                 c, cdb_valid, req_ready);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_flush();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_pending got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
